// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of pending stores. Entries are enqueued
// from the reservation station, marked committed in order by the
// instruction queue, and written to memory one at a time from the head.
module store_buffer #(
   parameter int DEPTH     = 4,
   parameter int IQ_ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   output logic                 rs_full_out,
   input  logic                 rs_store_enable_in,
   input  logic [2:0]           rs_func3_in,
   input  logic [31:0]          rs_addr_in,
   input  logic [31:0]          rs_data_in,
   input  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in,
   input  logic                 iq_commit_enable_in,
   input  logic                 clear_flag_in,
   output logic                 iq_write_enable_out,
   output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
   output logic                 iq_write_ready_out,
   output logic                 mc_store_enable_out,
   output logic [31:0]          mc_addr_out,
   output logic [1:0]           mc_len_out,
   output logic [31:0]          mc_data_out,
   input  logic                 mc_store_done_in
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, STORING} state_t;

   state_t        state;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] ccnt;

   logic [31:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [1:0]    len_mem  [DEPTH];

   logic          enq;
   logic          pop;
   logic          commit;
   logic [1:0]    enq_len;
   logic [CW-1:0] ccnt_next;
   logic [CW-1:0] count_next;
   logic [PW-1:0] head_next;
   logic [PW-1:0] tail_next;

   // Bit 2 of func3 only selects signedness for loads; stores ignore it.
   logic          unused_func3;
   assign unused_func3 = rs_func3_in[2];

   // Next-state arithmetic; a flush keeps only committed entries and drops a same-cycle enqueue.
   always_comb begin
      enq        = rs_store_enable_in && !rs_full_out && !clear_flag_in;
      pop        = (state == STORING) && mc_store_done_in;
      commit     = iq_commit_enable_in && (ccnt < count);
      enq_len    = (rs_func3_in[1:0] == 2'd2) ? 2'd3 : rs_func3_in[1:0];
      ccnt_next  = ccnt + CW'(commit) - CW'(pop);
      head_next  = head + PW'(pop);
      count_next = count + CW'(enq) - CW'(pop);
      tail_next  = tail + PW'(enq);
      if (clear_flag_in) begin
         count_next = ccnt_next;
         tail_next  = head_next + ccnt_next[PW-1:0];
      end
   end

   // Pointer, occupancy and full-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         ccnt        <= '0;
         rs_full_out <= 1'b0;
      end else if (rdy) begin
         head        <= head_next;
         tail        <= tail_next;
         count       <= count_next;
         ccnt        <= ccnt_next;
         rs_full_out <= (count_next == CW'(DEPTH));
      end
   end

   // Entry storage; written at the tail on an accepted enqueue.
   always_ff @(posedge clk) begin
      if (!rst && rdy && enq) begin
         addr_mem[tail] <= rs_addr_in;
         data_mem[tail] <= rs_data_in;
         len_mem[tail]  <= enq_len;
      end
   end

   // One-cycle acknowledgement to the instruction queue for each accepted enqueue.
   always_ff @(posedge clk) begin
      if (rst) begin
         iq_write_enable_out <= 1'b0;
         iq_write_ready_out  <= 1'b0;
         iq_write_idx_out    <= '0;
      end else if (rdy) begin
         iq_write_enable_out <= enq;
         iq_write_ready_out  <= enq;
         if (enq) begin
            iq_write_idx_out <= rs_pos_in_iq_in;
         end
      end
   end

   // Issue FSM: present the head entry to memory once committed, hold it until done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         mc_store_enable_out <= 1'b0;
         mc_addr_out         <= '0;
         mc_len_out          <= '0;
         mc_data_out         <= '0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               if (ccnt != '0) begin
                  state               <= STORING;
                  mc_store_enable_out <= 1'b1;
                  mc_addr_out         <= addr_mem[head];
                  mc_len_out          <= len_mem[head];
                  mc_data_out         <= data_mem[head];
               end
            end
            STORING: begin
               if (mc_store_done_in) begin
                  state               <= IDLE;
                  mc_store_enable_out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a directed vector table for the
// basic enqueue/commit/issue flow, then hand-written corner-case sequences.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rs_full_out;
   logic        rs_store_enable_in;
   logic [2:0]  rs_func3_in;
   logic [31:0] rs_addr_in;
   logic [31:0] rs_data_in;
   logic [3:0]  rs_pos_in_iq_in;
   logic        iq_commit_enable_in;
   logic        clear_flag_in;
   logic        iq_write_enable_out;
   logic [3:0]  iq_write_idx_out;
   logic        iq_write_ready_out;
   logic        mc_store_enable_out;
   logic [31:0] mc_addr_out;
   logic [1:0]  mc_len_out;
   logic [31:0] mc_data_out;
   logic        mc_store_done_in;

   int checks = 0;
   int errors = 0;

   store_buffer #(.DEPTH(4), .IQ_ADDR_W(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .rdy                 (rdy),
      .rs_full_out         (rs_full_out),
      .rs_store_enable_in  (rs_store_enable_in),
      .rs_func3_in         (rs_func3_in),
      .rs_addr_in          (rs_addr_in),
      .rs_data_in          (rs_data_in),
      .rs_pos_in_iq_in     (rs_pos_in_iq_in),
      .iq_commit_enable_in (iq_commit_enable_in),
      .clear_flag_in       (clear_flag_in),
      .iq_write_enable_out (iq_write_enable_out),
      .iq_write_idx_out    (iq_write_idx_out),
      .iq_write_ready_out  (iq_write_ready_out),
      .mc_store_enable_out (mc_store_enable_out),
      .mc_addr_out         (mc_addr_out),
      .mc_len_out          (mc_len_out),
      .mc_data_out         (mc_data_out),
      .mc_store_done_in    (mc_store_done_in)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic        en;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  pos;
      logic        cmt;
      logic        done;
      logic        e_full;
      logic        e_iq;
      logic [3:0]  e_idx;
      logic        e_mc;
      logic [31:0] e_addr;
      logic [1:0]  e_len;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mkVec(
      input logic en, input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] data, input logic [3:0] pos, input logic cmt,
      input logic done, input logic e_full, input logic e_iq,
      input logic [3:0] e_idx, input logic e_mc, input logic [31:0] e_addr,
      input logic [1:0] e_len, input logic [31:0] e_data);
      vec_t v;
      v.en = en; v.f3 = f3; v.addr = addr; v.data = data; v.pos = pos;
      v.cmt = cmt; v.done = done; v.e_full = e_full; v.e_iq = e_iq;
      v.e_idx = e_idx; v.e_mc = e_mc; v.e_addr = e_addr; v.e_len = e_len;
      v.e_data = e_data;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] pos,
                        input logic cmt, input logic clr, input logic done);
      rst                 = 1'b0;
      rdy                 = 1'b1;
      rs_store_enable_in  = en;
      rs_func3_in         = f3;
      rs_addr_in          = addr;
      rs_data_in          = data;
      rs_pos_in_iq_in     = pos;
      iq_commit_enable_in = cmt;
      clear_flag_in       = clr;
      mc_store_done_in    = done;
      tick();
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic enqueue(input logic [2:0] f3, input logic [31:0] addr, input logic [3:0] pos);
      drive(1'b1, f3, addr, ~addr, pos, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      drive(v.en, v.f3, v.addr, v.data, v.pos, v.cmt, 1'b0, v.done);
      tag = $sformatf("vec%0d", idx);
      checkOutput({tag, "_full"}, 32'(rs_full_out), 32'(v.e_full));
      checkOutput({tag, "_iq_en"}, 32'(iq_write_enable_out), 32'(v.e_iq));
      checkOutput({tag, "_iq_rdy"}, 32'(iq_write_ready_out), 32'(v.e_iq));
      if (v.e_iq) checkOutput({tag, "_iq_idx"}, 32'(iq_write_idx_out), 32'(v.e_idx));
      checkOutput({tag, "_mc_en"}, 32'(mc_store_enable_out), 32'(v.e_mc));
      checkOutput({tag, "_mc_addr"}, mc_addr_out, v.e_addr);
      checkOutput({tag, "_mc_len"}, 32'(mc_len_out), 32'(v.e_len));
      checkOutput({tag, "_mc_data"}, mc_data_out, v.e_data);
   endtask

   // Commit the oldest store, wait (bounded) for its request, check the address, complete it.
   task automatic drainOne(input logic [31:0] exp_addr, input string tag);
      logic got;
      got = 1'b0;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4 && !got; k++) begin
         idle();
         if (mc_store_enable_out) got = 1'b1;
      end
      checkOutput({tag, "_issue"}, 32'(got), 32'd1);
      checkOutput({tag, "_addr"}, mc_addr_out, exp_addr);
      checkOutput({tag, "_data"}, mc_data_out, ~exp_addr);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput({tag, "_done"}, 32'(mc_store_enable_out), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_full"}, 32'(rs_full_out), 32'd0);
      checkOutput({tag, "_iq_en"}, 32'(iq_write_enable_out), 32'd0);
      checkOutput({tag, "_iq_rdy"}, 32'(iq_write_ready_out), 32'd0);
      checkOutput({tag, "_mc_en"}, 32'(mc_store_enable_out), 32'd0);
      checkOutput({tag, "_mc_addr"}, mc_addr_out, 32'd0);
      checkOutput({tag, "_mc_len"}, 32'(mc_len_out), 32'd0);
      checkOutput({tag, "_mc_data"}, mc_data_out, 32'd0);
   endtask

   initial begin
      // Basic flow: sw issue, then sb/sh in order, then an ignored commit.
      vecs[0]  = mkVec(1, 3'd2, 32'h100, 32'hDEADBEEF, 4'd5, 0, 0, 0, 1, 4'd5, 0, 32'h0,   2'd0, 32'h0);
      vecs[1]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 1, 0, 0, 0, 4'd0, 0, 32'h0,   2'd0, 32'h0);
      vecs[2]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 0, 0, 0, 4'd0, 1, 32'h100, 2'd3, 32'hDEADBEEF);
      vecs[3]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 0, 0, 0, 4'd0, 1, 32'h100, 2'd3, 32'hDEADBEEF);
      vecs[4]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 1, 0, 0, 4'd0, 0, 32'h100, 2'd3, 32'hDEADBEEF);
      vecs[5]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 0, 0, 0, 4'd0, 0, 32'h100, 2'd3, 32'hDEADBEEF);
      vecs[6]  = mkVec(1, 3'd0, 32'h200, 32'h11,       4'd1, 0, 0, 0, 1, 4'd1, 0, 32'h100, 2'd3, 32'hDEADBEEF);
      vecs[7]  = mkVec(1, 3'd1, 32'h204, 32'h2222,     4'd2, 1, 0, 0, 1, 4'd2, 0, 32'h100, 2'd3, 32'hDEADBEEF);
      vecs[8]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 1, 0, 0, 0, 4'd0, 1, 32'h200, 2'd0, 32'h11);
      vecs[9]  = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 1, 0, 0, 4'd0, 0, 32'h200, 2'd0, 32'h11);
      vecs[10] = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 0, 0, 0, 4'd0, 1, 32'h204, 2'd1, 32'h2222);
      vecs[11] = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 1, 0, 0, 4'd0, 0, 32'h204, 2'd1, 32'h2222);
      vecs[12] = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 1, 0, 0, 0, 4'd0, 0, 32'h204, 2'd1, 32'h2222);
      vecs[13] = mkVec(0, 3'd0, 32'h0,   32'h0,        4'd0, 0, 0, 0, 0, 4'd0, 0, 32'h204, 2'd1, 32'h2222);

      rst = 1'b1; rdy = 1'b1;
      rs_store_enable_in = 1'b0; rs_func3_in = 3'd0; rs_addr_in = 32'h0;
      rs_data_in = 32'h0; rs_pos_in_iq_in = 4'd0; iq_commit_enable_in = 1'b0;
      clear_flag_in = 1'b0; mc_store_done_in = 1'b0;
      tick();
      tick();
      checkAllZero("reset");

      for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

      // Fill to full, fifth request ignored, one completion clears full.
      for (int i = 0; i < 4; i++) begin
         enqueue(3'd2, 32'h300 + 32'(i * 4), 4'(i));
         checkOutput($sformatf("fill%0d_full", i), 32'(rs_full_out), (i == 3) ? 32'd1 : 32'd0);
      end
      enqueue(3'd2, 32'h310, 4'd7);
      checkOutput("fifth_iq_en", 32'(iq_write_enable_out), 32'd0);
      checkOutput("fifth_full", 32'(rs_full_out), 32'd1);
      drainOne(32'h300, "full0");
      checkOutput("full_cleared", 32'(rs_full_out), 32'd0);
      drainOne(32'h304, "full1");
      drainOne(32'h308, "full2");
      drainOne(32'h30C, "full3");
      for (int i = 0; i < 3; i++) begin
         idle();
         checkOutput($sformatf("full_empty%0d_mc_en", i), 32'(mc_store_enable_out), 32'd0);
      end

      // Flush with three entries, one committed and issuing.
      enqueue(3'd2, 32'h400, 4'd1);
      enqueue(3'd2, 32'h404, 4'd2);
      enqueue(3'd2, 32'h408, 4'd3);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("flush_issue", 32'(mc_store_enable_out), 32'd1);
      checkOutput("flush_issue_addr", mc_addr_out, 32'h400);
      drive(1'b1, 3'd2, 32'h40C, 32'h0, 4'd9, 1'b0, 1'b1, 1'b0);
      checkOutput("flush_iq_dropped", 32'(iq_write_enable_out), 32'd0);
      checkOutput("flush_mc_held", 32'(mc_store_enable_out), 32'd1);
      checkOutput("flush_addr_held", mc_addr_out, 32'h400);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("flush_done", 32'(mc_store_enable_out), 32'd0);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         checkOutput($sformatf("flush_quiet%0d", i), 32'(mc_store_enable_out), 32'd0);
      end
      enqueue(3'd2, 32'h500, 4'd3);
      checkOutput("post_flush_iq_idx", 32'(iq_write_idx_out), 32'd3);
      drainOne(32'h500, "post_flush");

      // Six rounds to wrap the pointers.
      for (int i = 0; i < 6; i++) begin
         enqueue(3'd2, 32'h600 + 32'(i * 4), 4'(i + 8));
         checkOutput($sformatf("wrap%0d_iq_en", i), 32'(iq_write_enable_out), 32'd1);
         checkOutput($sformatf("wrap%0d_iq_idx", i), 32'(iq_write_idx_out), 32'(i + 8));
         drainOne(32'h600 + 32'(i * 4), $sformatf("wrap%0d", i));
      end

      // rdy low freezes a pending issue; reset mid-store clears everything.
      enqueue(3'd2, 32'h700, 4'd4);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
      rdy = 1'b0;
      iq_commit_enable_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("stall%0d_mc_en", i), 32'(mc_store_enable_out), 32'd0);
      end
      idle();
      checkOutput("stall_release_mc_en", 32'(mc_store_enable_out), 32'd1);
      checkOutput("stall_release_addr", mc_addr_out, 32'h700);
      rst = 1'b1;
      mc_store_done_in = 1'b1;
      tick();
      checkAllZero("mid_store_reset");
      for (int i = 0; i < 3; i++) begin
         idle();
         checkOutput($sformatf("after_reset%0d_mc_en", i), 32'(mc_store_enable_out), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
